branch_resolution_tracker: RTL and testbench
============================================

# branch_resolution_tracker

Tracks every conditional branch from fetch, where `global_branch_predictor` makes its guess, to execute, where the real outcome is known. It keeps the in-flight predictions in order in a small queue and compares each one with the resolved outcome. It drives the predictor's training write port (`write_en`, `pc_value`, `branch_taken`) and raises a registered mispredict/redirect to the fetch stage. It also keeps saturating accuracy counters for performance analysis.

## Interface
- `DEPTH`, 4: number of in-flight branch entries; power of two, at least 2.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_valid` in 1: fetch is issuing a predicted conditional branch this cycle.
- `fetch_pc` in 32: PC of that branch.
- `fetch_pred` in `prediction_choice`: direction predicted at fetch.
- `full` out 1: queue holds `DEPTH` entries; combinational from occupancy.
- `resolve_valid` in 1: execute resolves the oldest in-flight branch this cycle.
- `resolve_taken` in `prediction_choice`: actual direction.
- `resolve_target` in 32: actual target address, used only when taken.
- `update_en` out 1: predictor training write enable.
- `update_pc` out 32: PC to train.
- `update_taken` out `prediction_choice`: actual outcome to train.
- `mispredict` out 1: one-cycle pulse; fetch must redirect and flush its wrong-path work.
- `redirect_pc` out 32: correct next PC, valid while `mispredict` is high.
- `branch_count` out `CNT_W`: number of resolved branches.
- `mispredict_count` out `CNT_W`: number of mispredicted branches.
- `protocol_err` out 1: sticky error flag.

## Operation
- Storage is a circular queue of {pc, pred} with a write pointer, a read pointer and an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo `DEPTH`.
- Enqueue happens when `fetch_valid` is high and the queue is not full. It is also accepted when full if a correct resolve happens in the same cycle, because that resolve frees a slot.
- Dequeue happens when `resolve_valid` is high and the queue is not empty. The head entry is compared with `resolve_taken`:
  - Correct prediction: pop the head and increment `branch_count`.
  - Wrong prediction: increment both `branch_count` and `mispredict_count`. Clear the whole queue (count to 0, read pointer set equal to the write pointer), because every younger entry is on the wrong path.
  - Any `fetch_valid` in the same cycle is discarded, since it is wrong-path.
  - `redirect_pc` is `resolve_target` if the actual direction is taken, otherwise head pc + 4 (modulo 2^32).
- Every valid dequeue, correct or wrong, produces a predictor update: `update_pc` is the head pc and `update_taken` is `resolve_taken`.
- Counters saturate at all-ones and never wrap.
- `protocol_err` is set by either of these, and cleared only by `rst`:
  - `resolve_valid` while empty. The resolve is ignored: no update, no count.
  - A rejected enqueue, i.e. `fetch_valid` while full without a freeing correct resolve. The enqueue is dropped.
- Correct enqueue and dequeue in the same cycle leave the count unchanged and advance both pointers.

## Timing
- Reset values: all outputs 0, except `update_taken`, which is `not_take`; queue empty; pointers 0. `full` is 0 after reset.
- `update_en`, `update_pc`, `update_taken`, `mispredict`, `redirect_pc`, both counters and `protocol_err` are registered.
- A resolve sampled at edge N appears on outputs after edge N, during cycle N+1. `update_en` and `mispredict` are single-cycle pulses.
- A mispredict flush takes effect at edge N: in cycle N+1 the count is 0 and `full` is 0.
- A fetch entering at edge N can be resolved at the earliest at edge N+1.
- Asserting `rst` mid-operation immediately empties the queue and drops pulses and counters to 0. In-flight entries are lost.

## Test plan
- Reset, then enqueue pc 0x100 predicted take, then resolve take. Required: one cycle later `update_en`=1, `update_pc`=0x100, `update_taken`=take, `mispredict`=0; `branch_count`=1.
- Enqueue 0x200 pred not_take and 0x204 pred take, then resolve 0x200 as take with target 0x400. Required: `mispredict` pulses once, `redirect_pc`=0x400, queue empty. A later resolve with the queue empty sets `protocol_err`. `mispredict_count`=1.
- Mispredict not_take→not taken fall-through case: pc 0xFFFFFFFC predicted take, resolved not_take. Required: `redirect_pc`=0x00000000, which checks the wrap.
- Fill to 4 entries: `full`=1. A 5th fetch with no resolve is dropped and sets `protocol_err`. A 5th fetch together with a correct resolve is accepted and `full` stays 1.
- Mispredict resolve in the same cycle as `fetch_valid`: the fetch entry is discarded and the count is 0 afterwards.
- Preload `branch_count` near saturation with `CNT_W`=4: after 16+ resolves the counter stays at 0xF. Assert `rst` mid-stream: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/branch_resolution_tracker.sv
// branch_resolution_tracker: in-order queue of fetch-time branch predictions checked against execute outcomes,
// driving predictor training, mispredict redirect and saturating accuracy counters.
package brt_pkg;
  typedef enum logic {not_take = 1'b0, take = 1'b1} prediction_choice;
endpackage

module branch_resolution_tracker
  import brt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  prediction_choice fetch_pred,
  output logic             full,
  input  logic             resolve_valid,
  input  prediction_choice resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             update_en,
  output logic [31:0]      update_pc,
  output prediction_choice update_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             protocol_err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      mem_pc [DEPTH];
  prediction_choice mem_pred [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_n;
  logic             empty, deq, wrong, correct, enq, err;
  logic [31:0]      head_pc;
  prediction_choice head_pred;
  always_comb begin
    empty     = count == '0;
    full      = count == (AW+1)'(DEPTH);
    head_pc   = mem_pc[rd_ptr];
    head_pred = mem_pred[rd_ptr];
    deq       = resolve_valid && !empty;
    wrong     = deq && (head_pred != resolve_taken);
    correct   = deq && !wrong;
    enq       = fetch_valid && !wrong && (!full || correct);
    err       = (resolve_valid && empty) || (fetch_valid && full && !correct);
    count_n   = wrong ? '0 : count + (AW+1)'(enq) - (AW+1)'(correct);
  end
  always_ff @(posedge clk)
    if (enq) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_pred[wr_ptr] <= fetch_pred;
    end
  // A mispredict drops every younger entry by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      update_en        <= 1'b0;
      update_pc        <= '0;
      update_taken     <= not_take;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      protocol_err     <= 1'b0;
    end else begin
      count            <= count_n;
      wr_ptr           <= wr_ptr + AW'(enq);
      rd_ptr           <= wrong ? wr_ptr : rd_ptr + AW'(correct);
      update_en        <= deq;
      update_pc        <= deq ? head_pc : update_pc;
      update_taken     <= deq ? resolve_taken : update_taken;
      mispredict       <= wrong;
      redirect_pc      <= wrong ? (resolve_taken == take ? resolve_target : head_pc + 32'd4) : redirect_pc;
      branch_count     <= branch_count + CNT_W'(deq && !(&branch_count));
      mispredict_count <= mispredict_count + CNT_W'(wrong && !(&mispredict_count));
      protocol_err     <= protocol_err | err;
    end
endmodule

// File: tb/tb_branch_resolution_tracker.sv
// tb_branch_resolution_tracker: directed scoreboard bench with a reference queue model of the tracker.
module tb_branch_resolution_tracker;
  import brt_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = 4;
  localparam int CMAX = 2**CW - 1;

  typedef struct {logic [31:0] pc; prediction_choice pred;} ent_t;
  typedef struct {logic [31:0] pc; prediction_choice taken; logic mis; logic [31:0] rdr;} exp_t;

  logic clk = 0, rst = 1;
  logic fetch_valid = 0, resolve_valid = 0, full, update_en, mispredict, protocol_err;
  logic [31:0] fetch_pc = 0, resolve_target = 0, update_pc, redirect_pc;
  prediction_choice fetch_pred = not_take, resolve_taken = not_take, update_taken;
  logic [CW-1:0] branch_count, mispredict_count;

  ent_t mq[$];
  exp_t sb[$];
  int bc, mc, errors, checks;
  bit perr;

  branch_resolution_tracker #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
    .full(full), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .update_en(update_en), .update_pc(update_pc),
    .update_taken(update_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("update_en", 32'(update_en), 32'd1);
      chk("update_pc", update_pc, e.pc);
      chk("update_taken", 32'(update_taken), 32'(e.taken));
      chk("mispredict", 32'(mispredict), 32'(e.mis));
      if (e.mis) chk("redirect_pc", redirect_pc, e.rdr);
    end else begin
      chk("update_en_idle", 32'(update_en), 32'd0);
      chk("mispredict_idle", 32'(mispredict), 32'd0);
    end
    chk("branch_count", 32'(branch_count), 32'(bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(mc));
    chk("protocol_err", 32'(protocol_err), 32'(perr));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    bc = 0;
    mc = 0;
    perr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic cycle(input logic fv, input logic [31:0] fpc, input prediction_choice fp,
                       input logic rv, input prediction_choice rt, input logic [31:0] tgt);
    ent_t h;
    exp_t e;
    bit deq, wr, fm;
    fm = mq.size() == DEPTH;
    deq = rv && mq.size() != 0;
    wr = 0;
    if (rv && !deq) perr = 1;
    if (deq) begin
      h = mq.pop_front();
      wr = h.pred != rt;
      e.pc = h.pc;
      e.taken = rt;
      e.mis = wr;
      e.rdr = (rt == take) ? tgt : h.pc + 32'd4;
      sb.push_back(e);
      if (bc != CMAX) bc++;
      if (wr && mc != CMAX) mc++;
      if (wr) mq.delete();
    end
    if (fv && fm && !(deq && !wr)) perr = 1;
    else if (fv && !wr) begin
      h.pc = fpc;
      h.pred = fp;
      mq.push_back(h);
    end
    fetch_valid = fv; fetch_pc = fpc; fetch_pred = fp;
    resolve_valid = rv; resolve_taken = rt; resolve_target = tgt;
    @(posedge clk);
    #1;
    chk_state();
    fetch_valid = 0;
    resolve_valid = 0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_update_en", 32'(update_en), 32'd0);
    chk("rst_update_taken", 32'(update_taken), 32'(not_take));
    chk("rst_update_pc", update_pc, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    // Correct prediction
    cycle(1, 32'h100, take, 0, not_take, 0);
    cycle(0, 0, not_take, 1, take, 0);
    cycle(0, 0, not_take, 0, not_take, 0);
    // Mispredict flushes younger entry, then resolve on empty queue
    cycle(1, 32'h200, not_take, 0, not_take, 0);
    cycle(1, 32'h204, take, 0, not_take, 0);
    cycle(0, 0, not_take, 1, take, 32'h400);
    cycle(0, 0, not_take, 1, take, 32'h999);
    // Fall-through redirect wraps past 2^32
    do_reset();
    cycle(1, 32'hFFFF_FFFC, take, 0, not_take, 0);
    cycle(0, 0, not_take, 1, not_take, 32'h1234);
    // Fill, rejected 5th fetch, then 5th fetch with freeing resolve
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h10 + 32'(4*i), take, 0, not_take, 0);
    cycle(1, 32'h80, take, 0, not_take, 0);
    cycle(1, 32'h20, take, 1, take, 32'h50);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, not_take, 1, take, 32'h60);
    // Mispredict with same-cycle fetch discards the fetch
    do_reset();
    cycle(1, 32'h300, take, 0, not_take, 0);
    cycle(1, 32'h304, take, 1, not_take, 32'h0);
    cycle(0, 0, not_take, 1, take, 32'h0);
    // Counter saturation at CNT_W=4
    do_reset();
    cycle(1, 32'h500, take, 0, not_take, 0);
    for (int i = 0; i < 18; i++) cycle(1, 32'h504 + 32'(4*i), take, 1, take, 0);
    cycle(1, 32'h600, take, 1, not_take, 32'h700);
    cycle(1, 32'h604, take, 0, not_take, 0);
    cycle(1, 32'h608, not_take, 1, take, 32'h800);
    // Asynchronous reset mid-stream, between clock edges
    fetch_valid = 1; fetch_pc = 32'h900; fetch_pred = take;
    #2 rst = 1;
    #1;
    fetch_valid = 0;
    chk("arst_update_en", 32'(update_en), 32'd0);
    chk("arst_mispredict", 32'(mispredict), 32'd0);
    chk("arst_redirect_pc", redirect_pc, 32'd0);
    chk("arst_update_pc", update_pc, 32'd0);
    chk("arst_update_taken", 32'(update_taken), 32'(not_take));
    chk("arst_branch_count", 32'(branch_count), 32'd0);
    chk("arst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("arst_perr", 32'(protocol_err), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    cycle(0, 0, not_take, 1, take, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
